minibyte_memio: RTL and testbench
=================================

MINIBYTE_MEMIO -- requirements
Module: minibyte_memio

Interface
REQ-001 Parameter RAM_DEPTH, default 32, SHALL set the number of RAM bytes; it SHALL be a power of two from 8 to 128.
REQ-002 Port clk_in, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port addr_in, input, 8 bits: bus address driven by the CPU.
REQ-005 Port data_in, input, 8 bits: CPU write data.
REQ-006 Port we_in, input, 1 bit: CPU write enable.
REQ-007 Port data_out, output, 8 bits: read data returned to the CPU.
REQ-008 Port gpio_in, input, 8 bits: asynchronous external inputs.
REQ-009 Port gpio_out, output, 8 bits: registered external outputs.
REQ-010 Port irq_out, output, 1 bit: timer interrupt request.
REQ-011 Port load_en_in, input, 1 bit: loader mode.
REQ-012 Port load_valid_in, input, 1 bit: loader byte valid.
REQ-013 Port load_data_in, input, 8 bits: loader byte.
REQ-014 Port load_ready_out, output, 1 bit: loader can accept a byte.

Function
REQ-015 Memory map SHALL be:
- RAM: 0x00 to RAM_DEPTH-1.
- Unmapped: RAM_DEPTH to 0xEF; reads return 0x00 and writes are ignored.
- 0xF0 GPIO_OUT, read/write.
- 0xF1 GPIO_IN, read-only.
- 0xF2 TCNT, read/write.
- 0xF3 TCTRL, read/write.
- 0xF4 to 0xFF: reads return 0x00.
REQ-016 Reads SHALL be combinational: data_out SHALL reflect addr_in in the same cycle, with zero wait states.
REQ-017 A write with we_in=1 SHALL commit at the rising edge; a read of the same address in the next cycle SHALL return the new value.
REQ-018 GPIO_IN SHALL read gpio_in through a 2-flop synchronizer, giving 2 cycles of latency.
REQ-019 TCTRL fields SHALL be:
- bit0 EN.
- bits2:1 PS, with a tick every 2^PS cycles (1, 2, 4 or 8).
- bit3 IE.
- bit7 OVF, sticky.
- bits6:4 read as 0.
REQ-020 Prescaler SHALL be held at 0 while EN=0, and SHALL be cleared whenever TCTRL is written.
REQ-021 Each tick SHALL increment TCNT modulo 256; the tick that takes TCNT from 0xFF to 0x00 SHALL set OVF.
REQ-022 Writing TCTRL with bit7=1 SHALL clear OVF; writing bit7=0 SHALL leave OVF unchanged. The other fields SHALL take the written value.
REQ-023 Simultaneous events:
- CPU write to TCNT on a tick cycle: the write value wins and no increment occurs.
- OVF set and clear in the same cycle: set wins.
REQ-024 irq_out SHALL equal OVF AND IE, driven from registers with no combinational path from the bus.
REQ-025 Loader behaviour:
- load_ready_out SHALL equal load_en_in.
- While load_en_in=1, all CPU writes SHALL be ignored. CPU reads SHALL remain functional.
- On each cycle with load_en_in=1 and load_valid_in=1, RAM[ptr] SHALL get load_data_in and ptr SHALL increment.
- ptr SHALL wrap from RAM_DEPTH-1 to 0.
REQ-026 ptr SHALL be forced to 0 in every cycle where load_en_in=0.

Reset
REQ-027 While rst_in=0 the following SHALL be 0: gpio_out, TCNT, TCTRL (including OVF), prescaler, synchronizer flops and ptr. Consequently irq_out SHALL be 0.
REQ-028 RAM SHALL NOT be reset; its contents SHALL persist across reset.
REQ-029 Reset asserted in the middle of a load SHALL abort the load; ptr SHALL restart at 0.

Structure
REQ-030 Shared package minibyte_pkg SHALL hold:
- address constants ADDR_GPIO_OUT, ADDR_GPIO_IN, ADDR_TCNT and ADDR_TCTRL;
- TCTRL bit-index constants;
- the IO base constant 0xF0.
REQ-031 Timer and prescaler SHALL live in a sub-module minibyte_timer. RAM, decode and loader SHALL be in the top module.

Verification
REQ-032 Write 0xA5 to 0x05, then read 0x05 -> data_out=0xA5 the next cycle. Read 0x80 -> 0x00.
REQ-033 Write 0x3C to 0xF0 -> gpio_out=0x3C after the edge. Change gpio_in to 0x81 -> a read of 0xF1 returns 0x81 exactly 2 edges later.
REQ-034 Write TCNT=0xFE and TCTRL=0x0B (EN, PS=1, IE) -> TCNT=0xFF after 2 cycles. TCNT=0x00 with OVF=1 and irq_out=1 after 4 cycles. Then write TCTRL=0x8B -> irq_out=0.
REQ-035 Write TCNT=0x10 on the same cycle as a tick -> TCNT reads 0x10. A clear of OVF coinciding with a wrap -> OVF stays 1.
REQ-036 Set load_en_in=1 and stream 33 bytes 0x00 to 0x20 with RAM_DEPTH=32 -> RAM[0]=0x20 and RAM[1] to RAM[31] equal 0x01 to 0x1F. A CPU write during the load is ignored.
REQ-037 Assert rst_in in the middle of a load, then reload 1 byte -> it lands at RAM[0]. gpio_out and TCTRL read 0x00, while previously written RAM bytes are intact.

Source files
------------

// File: rtl/minibyte_pkg.sv
// Shared constants for the minibyte memory/IO block:
// IO register addresses and TCTRL field bit positions.
package minibyte_pkg;

  localparam logic [7:0] IO_BASE       = 8'hF0;
  localparam logic [7:0] ADDR_GPIO_OUT = IO_BASE + 8'd0;
  localparam logic [7:0] ADDR_GPIO_IN  = IO_BASE + 8'd1;
  localparam logic [7:0] ADDR_TCNT     = IO_BASE + 8'd2;
  localparam logic [7:0] ADDR_TCTRL    = IO_BASE + 8'd3;

  localparam int TCTRL_EN    = 0;
  localparam int TCTRL_PS_LO = 1;
  localparam int TCTRL_PS_HI = 2;
  localparam int TCTRL_IE    = 3;
  localparam int TCTRL_OVF   = 7;

endpackage

// File: rtl/minibyte_timer.sv
// 8-bit timer with 1/2/4/8 prescaler, sticky overflow and irq.
// Ports: clk_in, rst_in, tcnt/tctrl write strobes, wdata_in,
// tcnt_out, tctrl_out (read views), irq_out.
module minibyte_timer
  import minibyte_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tcnt_we_in,
  input  logic       tctrl_we_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] tcnt_out,
  output logic [7:0] tctrl_out,
  output logic       irq_out
);

  logic [7:0] tcnt_q, tcnt_d;
  logic [2:0] pre_q, pre_d;
  logic [1:0] ps_q, ps_d;
  logic       en_q, en_d;
  logic       ie_q, ie_d;
  logic       ovf_q, ovf_d;
  logic [2:0] mask;
  logic       tick;
  logic       wrap;

  always_comb begin
    mask = 3'd0;
    case (ps_q)
      2'd0:    mask = 3'd0;
      2'd1:    mask = 3'd1;
      2'd2:    mask = 3'd3;
      default: mask = 3'd7;
    endcase
    tick = en_q && (pre_q == mask);

    pre_d = pre_q + 3'd1;
    if (!en_q || tick || tctrl_we_in) pre_d = 3'd0;

    // A CPU write to TCNT beats a tick in the same cycle.
    tcnt_d = tcnt_q;
    if (tcnt_we_in)  tcnt_d = wdata_in;
    else if (tick)   tcnt_d = tcnt_q + 8'd1;
    wrap = tick && !tcnt_we_in && (tcnt_q == 8'hFF);

    en_d = en_q;
    ps_d = ps_q;
    ie_d = ie_q;
    if (tctrl_we_in) begin
      en_d = wdata_in[TCTRL_EN];
      ps_d = wdata_in[TCTRL_PS_HI:TCTRL_PS_LO];
      ie_d = wdata_in[TCTRL_IE];
    end

    // Set wins over a simultaneous write-one-to-clear.
    ovf_d = ovf_q;
    if (tctrl_we_in && wdata_in[TCTRL_OVF]) ovf_d = 1'b0;
    if (wrap) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tcnt_q <= 8'd0;
      pre_q  <= 3'd0;
      ps_q   <= 2'd0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      pre_q  <= pre_d;
      ps_q   <= ps_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      ovf_q  <= ovf_d;
    end
  end

  assign tcnt_out  = tcnt_q;
  assign tctrl_out = {ovf_q, 3'b000, ie_q, ps_q, en_q};
  assign irq_out   = ovf_q & ie_q;

endmodule

// File: rtl/minibyte_memio.sv
// Minibyte memory/IO: RAM, GPIO, timer and a byte-stream loader.
// Ports: CPU bus (addr/data/we/data_out), gpio_in/out, irq_out, loader.
module minibyte_memio
  import minibyte_pkg::*;
#(
  parameter int RAM_DEPTH = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic [7:0] data_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       irq_out,
  input  logic       load_en_in,
  input  logic       load_valid_in,
  input  logic [7:0] load_data_in,
  output logic       load_ready_out
);

  localparam int         AW       = $clog2(RAM_DEPTH);
  localparam logic [7:0] RAM_LAST = 8'(RAM_DEPTH - 1);

  logic [7:0]    ram_q [RAM_DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    gpio_q, gpio_d;
  logic [7:0]    sync1_q, sync2_q;

  logic          cpu_we, load_we, ram_hit, ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          tcnt_we, tctrl_we;
  logic [7:0]    tcnt, tctrl;

  always_comb begin
    // The loader owns the bus write path while enabled.
    cpu_we    = we_in & ~load_en_in;
    load_we   = load_en_in & load_valid_in;
    ram_hit   = addr_in <= RAM_LAST;
    ram_we    = load_we | (cpu_we & ram_hit);
    ram_waddr = load_en_in ? ptr_q : addr_in[AW-1:0];
    ram_wdata = load_en_in ? load_data_in : data_in;

    gpio_d = gpio_q;
    if (cpu_we && addr_in == ADDR_GPIO_OUT) gpio_d = data_in;
    tcnt_we  = cpu_we && (addr_in == ADDR_TCNT);
    tctrl_we = cpu_we && (addr_in == ADDR_TCTRL);

    ptr_d = ptr_q;
    if (!load_en_in)  ptr_d = '0;
    else if (load_we) ptr_d = ptr_q + 1'b1;
  end

  always_comb begin
    data_out = 8'h00;
    if (ram_hit) begin
      data_out = ram_q[addr_in[AW-1:0]];
    end else begin
      case (addr_in)
        ADDR_GPIO_OUT: data_out = gpio_q;
        ADDR_GPIO_IN:  data_out = sync2_q;
        ADDR_TCNT:     data_out = tcnt;
        ADDR_TCTRL:    data_out = tctrl;
        default:       data_out = 8'h00;
      endcase
    end
  end

  // RAM has no reset so contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_q   <= '0;
      gpio_q  <= 8'h00;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      ptr_q   <= ptr_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  minibyte_timer u_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tcnt_we_in  (tcnt_we),
    .tctrl_we_in (tctrl_we),
    .wdata_in    (data_in),
    .tcnt_out    (tcnt),
    .tctrl_out   (tctrl),
    .irq_out     (irq_out)
  );

  assign gpio_out       = gpio_q;
  assign load_ready_out = load_en_in;

endmodule

// File: tb/tb_minibyte_memio.sv
// Self-checking bench for minibyte_memio (RAM_DEPTH=32):
// directed scenarios plus randomized RAM/GPIO and timer runs.
module tb_minibyte_memio;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] addr_in, data_in;
  logic       we_in;
  logic [7:0] data_out;
  logic [7:0] gpio_in, gpio_out;
  logic       irq_out;
  logic       load_en_in, load_valid_in;
  logic [7:0] load_data_in;
  logic       load_ready_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram_m [32];
  bit         known [32];
  logic [7:0] gpio_m;

  minibyte_memio #(.RAM_DEPTH(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .we_in          (we_in),
    .data_out       (data_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .irq_out        (irq_out),
    .load_en_in     (load_en_in),
    .load_valid_in  (load_valid_in),
    .load_data_in   (load_data_in),
    .load_ready_out (load_ready_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    addr_in = a;
    data_in = d;
    we_in   = 1'b1;
    tick();
    we_in   = 1'b0;
  endtask

  task automatic rd(string tag, logic [7:0] a, logic [7:0] exp);
    addr_in = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  function automatic logic [7:0] model_rd(logic [7:0] a);
    if (a < 8'd32)      return ram_m[a[4:0]];
    if (a == 8'hF0)     return gpio_m;
    return 8'h00;
  endfunction

  initial begin
    logic [7:0] a, d, v, r;
    int p, n, total;

    rst_in = 1'b0;
    addr_in = 8'h00; data_in = 8'h00; we_in = 1'b0;
    gpio_in = 8'h00;
    load_en_in = 1'b0; load_valid_in = 1'b0; load_data_in = 8'h00;
    gpio_m = 8'h00;
    for (int i = 0; i < 32; i++) known[i] = 1'b0;
    tick(); tick();
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_irq", {7'd0, irq_out}, 8'h00);
    rst_in = 1'b1;
    tick();
    rd("rst_tcnt", 8'hF2, 8'h00);
    rd("rst_tctrl", 8'hF3, 8'h00);

    // RAM write/read and unmapped reads
    wr(8'h05, 8'hA5);
    ram_m[5] = 8'hA5; known[5] = 1'b1;
    rd("ram_rd_05", 8'h05, 8'hA5);
    rd("unmapped_80", 8'h80, 8'h00);
    wr(8'h80, 8'h77);
    rd("unmapped_80_wr", 8'h80, 8'h00);
    rd("hi_f5", 8'hF5, 8'h00);

    // GPIO out and input synchronizer latency
    wr(8'hF0, 8'h3C);
    gpio_m = 8'h3C;
    chk("gpio_out", gpio_out, 8'h3C);
    rd("gpio_out_rd", 8'hF0, 8'h3C);
    gpio_in = 8'h81;
    addr_in = 8'hF1;
    tick();
    chk("gpio_in_1edge", data_out, 8'h00);
    tick();
    chk("gpio_in_2edge", data_out, 8'h81);

    // Timer wrap with PS=1 and IE
    wr(8'hF2, 8'hFE);
    wr(8'hF3, 8'h0B);
    tick();
    rd("tcnt_1", 8'hF2, 8'hFE);
    tick();
    rd("tcnt_2", 8'hF2, 8'hFF);
    tick(); tick();
    rd("tcnt_wrap", 8'hF2, 8'h00);
    rd("tctrl_ovf", 8'hF3, 8'h8B);
    chk("irq_set", {7'd0, irq_out}, 8'h01);
    wr(8'hF3, 8'h8B);
    chk("irq_clr", {7'd0, irq_out}, 8'h00);
    rd("tctrl_clr", 8'hF3, 8'h0B);

    // TCNT write on a tick cycle wins
    tick();
    wr(8'hF2, 8'h10);
    rd("tcnt_wr_wins", 8'hF2, 8'h10);
    tick(); tick();
    rd("tcnt_resume", 8'hF2, 8'h11);

    // OVF clear coinciding with wrap: set wins
    wr(8'hF3, 8'h08);
    wr(8'hF2, 8'hFF);
    wr(8'hF3, 8'h09);
    wr(8'hF3, 8'h89);
    rd("ovf_set_wins", 8'hF3, 8'h89);
    chk("irq_set_wins", {7'd0, irq_out}, 8'h01);
    wr(8'hF3, 8'h80);
    rd("tctrl_off", 8'hF3, 8'h00);
    chk("irq_off", {7'd0, irq_out}, 8'h00);

    // Random timer runs: ticks = floor(cycles / 2^PS)
    for (int k = 0; k < 6; k++) begin
      v = 8'($urandom);
      p = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 40));
      wr(8'hF3, 8'h80);
      wr(8'hF2, v);
      wr(8'hF3, 8'(1 + (p << 1)));
      repeat (n) tick();
      total = int'(v) + (n >> p);
      rd("rnd_tcnt", 8'hF2, 8'(total % 256));
      rd("rnd_tctrl", 8'hF3,
         8'((total >= 256 ? 8'h80 : 8'h00) | 1 | (p << 1)));
      chk("rnd_irq", {7'd0, irq_out}, 8'h00);
    end
    wr(8'hF3, 8'h80);

    // Random RAM/GPIO traffic against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 8'($urandom_range(0, 31));
        2:       a = 8'($urandom_range(32, 8'hEF));
        default: a = ($urandom_range(0, 1) == 0) ? 8'hF0
                     : 8'($urandom_range(8'hF4, 8'hFF));
      endcase
      d = 8'($urandom);
      wr(a, d);
      if (a < 8'd32) begin
        ram_m[a[4:0]] = d;
        known[a[4:0]] = 1'b1;
      end else if (a == 8'hF0) begin
        gpio_m = d;
      end
      r = 8'($urandom);
      if ((r >= 8'hF1 && r <= 8'hF3) || (r < 8'd32 && !known[r[4:0]]))
        r = a;
      rd("rnd_rd", r, model_rd(r));
    end
    chk("rnd_gpio_out", gpio_out, gpio_m);

    // Loader: 33 bytes wrap; CPU writes ignored
    load_en_in = 1'b1;
    addr_in = 8'hF0; data_in = 8'hFF; we_in = 1'b1;
    #1;
    chk("ready_hi", {7'd0, load_ready_out}, 8'h01);
    for (int i = 0; i <= 32; i++) begin
      load_valid_in = 1'b1;
      load_data_in  = 8'(i);
      tick();
    end
    for (int i = 0; i <= 32; i++) ram_m[i % 32] = 8'(i);
    load_valid_in = 1'b0;
    we_in = 1'b0;
    load_en_in = 1'b0;
    #1;
    chk("ready_lo", {7'd0, load_ready_out}, 8'h00);
    chk("load_gpio_kept", gpio_out, gpio_m);
    for (int i = 0; i < 32; i++) rd("load_ram", 8'(i), ram_m[i]);

    // Reset in mid-load, then reload one byte
    load_en_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_valid_in = 1'b1;
      load_data_in  = 8'hC0 + 8'(i);
      tick();
      ram_m[i] = 8'hC0 + 8'(i);
    end
    load_valid_in = 1'b0;
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    load_valid_in = 1'b1;
    load_data_in  = 8'h5A;
    tick();
    ram_m[0] = 8'h5A;
    load_valid_in = 1'b0;
    load_en_in = 1'b0;
    tick();
    chk("rst2_gpio_out", gpio_out, 8'h00);
    rd("rst2_tctrl", 8'hF3, 8'h00);
    rd("rst2_tcnt", 8'hF2, 8'h00);
    chk("rst2_irq", {7'd0, irq_out}, 8'h00);
    for (int i = 0; i < 32; i++) rd("rst2_ram", 8'(i), ram_m[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
